morse_decoder: RTL and testbench
================================

Name: morse_decoder

Overview:
- Downstream datapath partner of the single-button texter controller.
- Accumulates dit/dash symbols into a per-character buffer under the controller's one-cycle strobes (nxt_char, nxt_bit, out_char, out_space, back_sp).
- Reports dc_error back to the controller.
- Emits one ASCII byte per output strobe to the display/UART stage as a one-cycle valid pulse.

Parameters:
- EMIT_ERR, 0: 0 = an out_char issued while dc_error=1 produces no output; 1 = it emits ERR_CODE.
- ERR_CODE, 8'h3F: ASCII byte emitted on an error when EMIT_ERR=1.

Ports:
- clk  in  1  system clock (50 MHz), all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- nxt_char  in  1  clear symbol buffer, start new character
- nxt_bit  in  1  append one symbol, value from dash_dit
- dash_dit  in  1  symbol value sampled with nxt_bit: 1 = dash, 0 = dit
- out_char  in  1  decode buffer and emit character
- out_space  in  1  emit ASCII space 8'h20
- back_sp  in  1  emit ASCII backspace 8'h08
- dc_error  out  1  current buffer is not a legal code (to controller)
- char_out  out  8  ASCII byte, held until next emission
- char_valid  out  1  one-cycle pulse qualifying char_out
- sym_len  out  3  current buffer length 0..6 (debug/LED)

Behaviour:
- Reset (reset_n=0 at a rising edge): pattern=0, sym_len=0, ovf=0, char_out=8'h00, char_valid=0. Reset overrides every strobe in the same cycle. A reset in the middle of a character discards it.
- Buffer:
  - pattern is a 6-bit register. Symbol k (0 = first keyed) is stored at bit k. sym_len counts stored symbols.
  - nxt_bit with sym_len<6: pattern[sym_len]<=dash_dit and sym_len<=sym_len+1.
  - nxt_bit with sym_len==6: set sticky ovf; pattern and sym_len are unchanged (no wrap).
  - nxt_char: pattern<=0, sym_len<=0, ovf<=0.
  - nxt_char and nxt_bit in the same cycle: clear, then append. Result is sym_len=1 and pattern[0]=dash_dit.
- dc_error:
  - Purely combinational from registered pattern, sym_len and ovf. There is no input-to-output path.
  - Asserted when sym_len==0, when ovf=1, or when (sym_len,pattern) is absent from the table.
  - Valid the cycle after the last nxt_bit. The controller samples it at least 2 cycles later.
- Table:
  - A-Z, upper case, standard ITU codes of length 1-4.
  - Digits 0-9, length 5.
  - Without the optional feature, any 6-symbol pattern is illegal.
- Emission:
  - One-cycle latency: a strobe at edge N gives char_valid=1 with the new char_out after edge N. char_valid is low on all other cycles.
  - Priority when strobes coincide: back_sp > out_space > out_char. Only one byte is emitted per cycle.
  - out_char with dc_error=0: emit the table ASCII.
  - out_char with dc_error=1: EMIT_ERR=0 gives no pulse and char_out unchanged; EMIT_ERR=1 emits ERR_CODE.
  - Emission does not clear the buffer; only nxt_char or reset clears it.
  - back_sp is a 1-cycle pulse sourced from the controller. The downstream stage erases on 8'h08.
- Back-to-back strobes on consecutive cycles each produce their own pulse.

Optional Feature:
- Macro: MORSE_PUNCT_EN.
- Defined: the table adds 6-symbol punctuation: '.' .-.-.- (8'h2E), ',' --..-- (8'h2C), '?' ..--.. (8'h3F), '/' -..-. (8'h2F, 5 symbols). These patterns clear dc_error.
- Undefined: these patterns assert dc_error. All other behaviour is identical.

Decomposition:
- Package morse_pkg holds:
  - MAX_SYM=6
  - ASCII constants SPACE=8'h20, BKSP=8'h08, NUL=8'h00
  - the pattern/length encoding convention
- Sub-module morse_lut, combinational: inputs len[2:0] and pattern[5:0]; outputs ascii[7:0] and legal. The MORSE_PUNCT_EN guard lives inside morse_lut.
- morse_decoder holds the buffer, ovf, the priority mux and the output registers.

Test Plan:
- Reset then idle: char_valid=0, char_out=8'h00, sym_len=0, dc_error=1.
- 'A': nxt_char, then nxt_bit(0), then nxt_bit(1), then out_char. Expect dc_error=0 and sym_len=2; char_valid for exactly 1 cycle with char_out=8'h41 one cycle after out_char.
- '5' then '0': key ..... and ----- each followed by out_char. Expect 8'h35 then 8'h30. A 7th nxt_bit after six dashes sets ovf, holds sym_len=6 and keeps dc_error=1.
- Illegal: key ..-- then out_char.
  - EMIT_ERR=0: no pulse.
  - EMIT_ERR=1: char_out=8'h3F with one pulse.
- Simultaneous: back_sp and out_space in the same cycle emit only 8'h08. out_space next cycle emits 8'h20. nxt_char and nxt_bit(1) together give sym_len=1 and pattern=6'b000001.
- Reset mid-char: key three dits, drop reset_n for one cycle. Expect sym_len=0 and ovf=0. Then ..--.. with out_char gives 8'h3F when MORSE_PUNCT_EN is defined, and dc_error with no pulse when it is undefined (EMIT_ERR=0).

Source files
------------

// File: rtl/morse_pkg.sv
// Shared constants and the symbol-buffer encoding used by the Morse decoder.
// Buffer convention: symbol k (0 = first keyed) lives at pattern bit k,
// 1 = dash, 0 = dit; bits at and above the length are always zero.
package morse_pkg;

  localparam int unsigned MAX_SYM = 6;
  localparam int unsigned SYM_W   = 3;
  localparam int unsigned PAT_W   = 6;
  localparam int unsigned CHAR_W  = 8;

  localparam logic [CHAR_W-1:0] SPACE = 8'h20;
  localparam logic [CHAR_W-1:0] BKSP  = 8'h08;
  localparam logic [CHAR_W-1:0] NUL   = 8'h00;

  // Table entry: code is written in keying order, first symbol as the MSB
  // of the low len bits, so entries read like the printed Morse code.
  typedef struct packed {
    logic [SYM_W-1:0]  len;
    logic [PAT_W-1:0]  code;
    logic [CHAR_W-1:0] ascii;
  } morse_entry_t;

  // Convert a keying-order code into the buffer's bit-k-is-symbol-k layout.
  function automatic logic [PAT_W-1:0] to_pattern(input logic [SYM_W-1:0] len,
                                                  input logic [PAT_W-1:0] code);
    logic [PAT_W-1:0] p;
    p = '0;
    for (int k = 0; k < int'(PAT_W); k++) begin
      if (k < int'(len)) p[k] = code[SYM_W'(int'(len) - 1 - k)];
    end
    return p;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse code lookup: (len, pattern) -> ASCII plus legality.
// Optional macro MORSE_PUNCT_EN adds the . , ? / punctuation codes.
module morse_lut
  import morse_pkg::*;
(
  input  logic [SYM_W-1:0]  len,
  input  logic [PAT_W-1:0]  pattern,
  output logic [CHAR_W-1:0] ascii,
  output logic              legal
);

  localparam int unsigned N_BASE = 36;

  localparam morse_entry_t BASE_TABLE [N_BASE] = '{
    '{3'd2, 6'b01,    8'h41}, '{3'd4, 6'b1000,  8'h42}, '{3'd4, 6'b1010,  8'h43},
    '{3'd3, 6'b100,   8'h44}, '{3'd1, 6'b0,     8'h45}, '{3'd4, 6'b0010,  8'h46},
    '{3'd3, 6'b110,   8'h47}, '{3'd4, 6'b0000,  8'h48}, '{3'd2, 6'b00,    8'h49},
    '{3'd4, 6'b0111,  8'h4A}, '{3'd3, 6'b101,   8'h4B}, '{3'd4, 6'b0100,  8'h4C},
    '{3'd2, 6'b11,    8'h4D}, '{3'd2, 6'b10,    8'h4E}, '{3'd3, 6'b111,   8'h4F},
    '{3'd4, 6'b0110,  8'h50}, '{3'd4, 6'b1101,  8'h51}, '{3'd3, 6'b010,   8'h52},
    '{3'd3, 6'b000,   8'h53}, '{3'd1, 6'b1,     8'h54}, '{3'd3, 6'b001,   8'h55},
    '{3'd4, 6'b0001,  8'h56}, '{3'd3, 6'b011,   8'h57}, '{3'd4, 6'b1001,  8'h58},
    '{3'd4, 6'b1011,  8'h59}, '{3'd4, 6'b1100,  8'h5A},
    '{3'd5, 6'b11111, 8'h30}, '{3'd5, 6'b01111, 8'h31}, '{3'd5, 6'b00111, 8'h32},
    '{3'd5, 6'b00011, 8'h33}, '{3'd5, 6'b00001, 8'h34}, '{3'd5, 6'b00000, 8'h35},
    '{3'd5, 6'b10000, 8'h36}, '{3'd5, 6'b11000, 8'h37}, '{3'd5, 6'b11100, 8'h38},
    '{3'd5, 6'b11110, 8'h39}
  };

`ifdef MORSE_PUNCT_EN
  localparam int unsigned N_PUNCT = 4;

  localparam morse_entry_t PUNCT_TABLE [N_PUNCT] = '{
    '{3'd6, 6'b010101, 8'h2E}, '{3'd6, 6'b110011, 8'h2C},
    '{3'd6, 6'b001100, 8'h3F}, '{3'd5, 6'b10010,  8'h2F}
  };
`endif

  // Search the table; length 0 never matches, so an empty buffer is illegal.
  always_comb begin
    ascii = NUL;
    legal = 1'b0;
    for (int i = 0; i < int'(N_BASE); i++) begin
      if (len == BASE_TABLE[i].len &&
          pattern == to_pattern(BASE_TABLE[i].len, BASE_TABLE[i].code)) begin
        legal = 1'b1;
        ascii = BASE_TABLE[i].ascii;
      end
    end
`ifdef MORSE_PUNCT_EN
    for (int i = 0; i < int'(N_PUNCT); i++) begin
      if (len == PUNCT_TABLE[i].len &&
          pattern == to_pattern(PUNCT_TABLE[i].len, PUNCT_TABLE[i].code)) begin
        legal = 1'b1;
        ascii = PUNCT_TABLE[i].ascii;
      end
    end
`endif
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse symbol accumulator and character emitter fed by the single-button
// texter controller. Optional macro MORSE_PUNCT_EN (inside morse_lut)
// enables punctuation decoding.
module morse_decoder
  import morse_pkg::*;
#(
  parameter bit                EMIT_ERR = 1'b0,
  parameter logic [CHAR_W-1:0] ERR_CODE = 8'h3F
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              nxt_char,
  input  logic              nxt_bit,
  input  logic              dash_dit,
  input  logic              out_char,
  input  logic              out_space,
  input  logic              back_sp,
  output logic              dc_error,
  output logic [CHAR_W-1:0] char_out,
  output logic              char_valid,
  output logic [SYM_W-1:0]  sym_len
);

  logic [PAT_W-1:0]  pattern;
  logic              ovf;
  logic [CHAR_W-1:0] lut_ascii;
  logic              lut_legal;

  morse_lut u_lut (
    .len     (sym_len),
    .pattern (pattern),
    .ascii   (lut_ascii),
    .legal   (lut_legal)
  );

  // Error flag depends only on registered buffer state.
  assign dc_error = (sym_len == '0) | ovf | ~lut_legal;

  // Symbol buffer: clear on nxt_char, then append on nxt_bit; overflow is sticky.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pattern <= '0;
      sym_len <= '0;
      ovf     <= 1'b0;
    end else if (nxt_char) begin
      pattern <= PAT_W'(dash_dit & nxt_bit);
      sym_len <= SYM_W'(nxt_bit);
      ovf     <= 1'b0;
    end else if (nxt_bit) begin
      if (sym_len < SYM_W'(MAX_SYM)) begin
        pattern[sym_len] <= dash_dit;
        sym_len          <= sym_len + SYM_W'(1);
      end else begin
        ovf <= 1'b1;
      end
    end
  end

  // Output byte with priority back_sp > out_space > out_char; one pulse per strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      char_out   <= NUL;
      char_valid <= 1'b0;
    end else begin
      char_valid <= 1'b0;
      if (back_sp) begin
        char_out   <= BKSP;
        char_valid <= 1'b1;
      end else if (out_space) begin
        char_out   <= SPACE;
        char_valid <= 1'b1;
      end else if (out_char) begin
        if (!dc_error) begin
          char_out   <= lut_ascii;
          char_valid <= 1'b1;
        end else if (EMIT_ERR) begin
          char_out   <= ERR_CODE;
          char_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: two instances (EMIT_ERR=0 and 1) share stimulus
// and are compared every cycle against a string-keyed reference model.
module tb_morse_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, nxt_char, nxt_bit, dash_dit, out_char, out_space, back_sp;
  logic       dc_error0, dc_error1, char_valid0, char_valid1;
  logic [7:0] char_out0, char_out1;
  logic [2:0] sym_len0, sym_len1;

  morse_decoder #(.EMIT_ERR(1'b0), .ERR_CODE(8'h3F)) dut0 (
    .clk(clk), .reset_n(reset_n), .nxt_char(nxt_char), .nxt_bit(nxt_bit),
    .dash_dit(dash_dit), .out_char(out_char), .out_space(out_space), .back_sp(back_sp),
    .dc_error(dc_error0), .char_out(char_out0), .char_valid(char_valid0), .sym_len(sym_len0)
  );

  morse_decoder #(.EMIT_ERR(1'b1), .ERR_CODE(8'h3F)) dut1 (
    .clk(clk), .reset_n(reset_n), .nxt_char(nxt_char), .nxt_bit(nxt_bit),
    .dash_dit(dash_dit), .out_char(out_char), .out_space(out_space), .back_sp(back_sp),
    .dc_error(dc_error1), .char_out(char_out1), .char_valid(char_valid1), .sym_len(sym_len1)
  );

  string letters [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string digits [10]  = '{"-----", ".----", "..---", "...--", "....-",
                          ".....", "-....", "--...", "---..", "----."};
  string puncts [4]   = '{".-.-.-", "--..--", "..--..", "-..-."};
  logic [7:0] punct_ascii [4] = '{8'h2E, 8'h2C, 8'h3F, 8'h2F};

  logic [7:0] code_tab [string];

  // Reference model state: symbols as a queue, outputs per instance.
  bit         q [$];
  bit         m_ovf;
  logic [7:0] m_out0, m_out1;
  bit         m_v0, m_v1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic string pat_str();
    string s = "";
    foreach (q[i]) s = {s, q[i] ? "-" : "."};
    return s;
  endfunction

  function automatic bit m_err();
    return (q.size() == 0) || m_ovf || !code_tab.exists(pat_str());
  endfunction

  // Apply one cycle of inputs, advance the model, compare all outputs.
  task automatic step(input bit r, input bit nc, input bit nb, input bit dd,
                      input bit oc, input bit os, input bit bs);
    bit         err;
    logic [7:0] asc;
    reset_n = r; nxt_char = nc; nxt_bit = nb; dash_dit = dd;
    out_char = oc; out_space = os; back_sp = bs;
    err = m_err();
    asc = err ? 8'h00 : code_tab[pat_str()];
    @(posedge clk);
    #1;
    if (!r) begin
      q.delete(); m_ovf = 0;
      m_out0 = 8'h00; m_out1 = 8'h00; m_v0 = 0; m_v1 = 0;
    end else begin
      m_v0 = 0; m_v1 = 0;
      if (bs) begin
        m_out0 = 8'h08; m_out1 = 8'h08; m_v0 = 1; m_v1 = 1;
      end else if (os) begin
        m_out0 = 8'h20; m_out1 = 8'h20; m_v0 = 1; m_v1 = 1;
      end else if (oc) begin
        if (!err) begin
          m_out0 = asc; m_out1 = asc; m_v0 = 1; m_v1 = 1;
        end else begin
          m_out1 = 8'h3F; m_v1 = 1;
        end
      end
      if (nc) begin
        q.delete(); m_ovf = 0;
      end
      if (nb) begin
        if (q.size() < 6) q.push_back(dd);
        else m_ovf = 1;
      end
    end
    check("char_valid0", 32'(char_valid0), 32'(m_v0));
    check("char_out0",   32'(char_out0),   32'(m_out0));
    check("char_valid1", 32'(char_valid1), 32'(m_v1));
    check("char_out1",   32'(char_out1),   32'(m_out1));
    check("sym_len0",    32'(sym_len0),    32'(q.size()));
    check("sym_len1",    32'(sym_len1),    32'(q.size()));
    check("dc_error0",   32'(dc_error0),   32'(m_err()));
    check("dc_error1",   32'(dc_error1),   32'(m_err()));
    reset_n = 1; nxt_char = 0; nxt_bit = 0; dash_dit = 0;
    out_char = 0; out_space = 0; back_sp = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  // nxt_char then one nxt_bit per symbol of the dot/dash string.
  task automatic key(input string s);
    step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      c = s[i];
      step(1, 0, 1, c == 8'h2D, 0, 0, 0);
    end
  endtask

  task automatic emit();
    step(1, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    foreach (letters[i]) code_tab[letters[i]] = 8'h41 + 8'(i);
    foreach (digits[i])  code_tab[digits[i]]  = 8'h30 + 8'(i);
`ifdef MORSE_PUNCT_EN
    foreach (puncts[i])  code_tab[puncts[i]]  = punct_ascii[i];
`endif
    m_out0 = 8'h00; m_out1 = 8'h00;
    reset_n = 0; nxt_char = 0; nxt_bit = 0; dash_dit = 0;
    out_char = 0; out_space = 0; back_sp = 0;

    // Reset then idle
    step(0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // 'A'
    key(".-"); idle(1); emit(); idle(2);

    // '5', '0', then overflow on six dashes plus one more
    key("....."); emit(); idle(1);
    key("-----"); emit(); idle(1);
    key("------"); step(1, 0, 1, 1, 0, 0, 0); emit(); idle(1);

    // Illegal pattern
    key("..--"); emit(); idle(1);

    // Coincident strobes
    step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 1, 1);
    step(1, 1, 1, 1, 0, 0, 0); emit(); idle(1);
    step(1, 1, 1, 0, 1, 0, 0); emit(); idle(1);

    // Reset mid-character, then punctuation / slash patterns
    key("..."); step(0, 0, 1, 1, 1, 0, 0); idle(1);
    key("..--.."); emit(); idle(1);
    key("-..-."); emit(); idle(1);
    key(".-.-.-"); emit(); emit();

    // Random characters (legal, punctuation, or junk) with random gaps
    for (int n = 0; n < 60; n++) begin
      string s;
      int    sel;
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      s = letters[$urandom_range(0, 25)];
      else if (sel == 1) s = digits[$urandom_range(0, 9)];
      else if (sel == 2) s = puncts[$urandom_range(0, 3)];
      else begin
        s = "";
        for (int k = 0; k < int'($urandom_range(0, 7)); k++)
          s = {s, ($urandom_range(0, 1) != 0) ? "-" : "."};
      end
      key(s);
      idle(int'($urandom_range(0, 2)));
      sel = int'($urandom_range(0, 9));
      step(1, 0, 0, 0, 1, sel == 0, sel == 1);
      idle(int'($urandom_range(0, 2)));
    end

    // Fully random strobe traffic
    for (int n = 0; n < 500; n++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 1) != 0,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
